// File: rtl/wb_stage.sv
// Writeback stage: registers execute results, forms the writeback value (ALU/load/PC+4/CSR),
// drives the register-file write port and forwarding tap, and counts retired instructions.
module wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic             ex_reg_we,
  input  logic [4:0]       ex_rd,
  input  logic [1:0]       ex_wb_sel,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic [XLEN-1:0]  ex_pc_plus4,
  input  logic [XLEN-1:0]  ex_csr_rdata,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [XLEN-1:0]  rf_wd,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic {StLive, StHold} state_e;

  state_e            state_q, state_d;
  logic              hold;
  logic              capture;
  logic              wb_valid, wb_reg_we;
  logic [4:0]        wb_rd;
  logic [1:0]        wb_sel;
  logic [2:0]        wb_funct3;
  logic [XLEN-1:0]   wb_alu_result, wb_pc_plus4, wb_csr_rdata;
  logic [XLEN-1:0]   rdata_q;
  logic [CNT_W-1:0]  instret_q;
  logic [XLEN-1:0]   src, ld;
  logic [1:0]        off;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  // A flush during a stall is ignored because the whole register simply holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_reg_we     <= 1'b0;
      wb_rd         <= '0;
      wb_sel        <= '0;
      wb_funct3     <= '0;
      wb_alu_result <= '0;
      wb_pc_plus4   <= '0;
      wb_csr_rdata  <= '0;
    end else if (!stall) begin
      wb_valid      <= ex_valid & ~flush;
      wb_reg_we     <= ex_reg_we;
      wb_rd         <= ex_rd;
      wb_sel        <= ex_wb_sel;
      wb_funct3     <= ex_funct3;
      wb_alu_result <= ex_alu_result;
      wb_pc_plus4   <= ex_pc_plus4;
      wb_csr_rdata  <= ex_csr_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLive;
    end else begin
      state_q <= state_d;
    end
  end

  // dmem only presents the load data for one cycle, so snapshot it when a stall begins.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      StLive: begin
        if (stall && wb_valid) begin
          state_d = StHold;
          capture = 1'b1;
        end
      end
      StHold: begin
        if (!stall) state_d = StLive;
      end
      default: state_d = StLive;
    endcase
  end

  assign hold = (state_q == StHold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q <= dmem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (wb_valid && !stall) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Halves ignore off[0]: misaligned halves are not trapped.
  always_comb begin
    src     = hold ? rdata_q : dmem_rdata;
    off     = wb_alu_result[1:0];
    ld_byte = src[{off, 3'b000} +: 8];
    ld_half = off[1] ? src[31:16] : src[15:0];
    case (wb_funct3)
      3'b000:  ld = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld = {{(XLEN-16){1'b0}}, ld_half};
      default: ld = src;
    endcase
  end

  always_comb begin
    case (wb_sel)
      2'b00:   rf_wd = wb_alu_result;
      2'b01:   rf_wd = ld;
      2'b10:   rf_wd = wb_pc_plus4;
      default: rf_wd = wb_csr_rdata;
    endcase
  end

  assign rf_we     = wb_valid & wb_reg_we & (wb_rd != 5'd0);
  assign rf_wa     = wb_rd;
  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_wa;
  assign fwd_data  = rf_wd;
  assign instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: vector table through a scoreboard queue, plus stall, reset and wrap sequences.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic        ex_valid, ex_reg_we;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wb_sel;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result, ex_pc_plus4, ex_csr_rdata, dmem_rdata;
  logic        rf_we, fwd_valid, w_rf_we, w_fwd_valid;
  logic [4:0]  rf_wa, fwd_rd, w_rf_wa, w_fwd_rd;
  logic [31:0] rf_wd, fwd_data, w_rf_wd, w_fwd_data;
  logic [31:0] instret;
  logic [3:0]  w_instret;

  wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_reg_we(ex_reg_we), .ex_rd(ex_rd), .ex_wb_sel(ex_wb_sel),
    .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_pc_plus4(ex_pc_plus4),
    .ex_csr_rdata(ex_csr_rdata), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instret(instret)
  );

  // Narrow counter instance so wrap-around is reachable in a few cycles.
  wb_stage #(.XLEN(32), .CNT_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_reg_we(ex_reg_we), .ex_rd(ex_rd), .ex_wb_sel(ex_wb_sel),
    .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_pc_plus4(ex_pc_plus4),
    .ex_csr_rdata(ex_csr_rdata), .dmem_rdata(dmem_rdata),
    .rf_we(w_rf_we), .rf_wa(w_rf_wa), .rf_wd(w_rf_wd),
    .fwd_valid(w_fwd_valid), .fwd_rd(w_fwd_rd), .fwd_data(w_fwd_data), .instret(w_instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, reg_we, flush;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu, pc4, csr, dmem;
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] cnt;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt = 0;
  exp_t        sb[$];
  vec_t        vecs[15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic we, input logic fl, input logic [4:0] rd,
                              input logic [1:0] sel, input logic [2:0] f3,
                              input logic [31:0] alu, input logic [31:0] pc4,
                              input logic [31:0] csr, input logic [31:0] dmem,
                              input logic ewe, input logic [31:0] ewd);
    vec_t r;
    r.valid = v; r.reg_we = we; r.flush = fl; r.rd = rd; r.sel = sel; r.f3 = f3;
    r.alu = alu; r.pc4 = pc4; r.csr = csr; r.dmem = dmem; r.exp_we = ewe; r.exp_wd = ewd;
    return r;
  endfunction

  task automatic drive_ex(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                          input logic [2:0] f3, input logic [31:0] alu);
    ex_valid = v; ex_reg_we = 1'b1; ex_rd = rd; ex_wb_sel = sel; ex_funct3 = f3;
    ex_alu_result = alu; ex_pc_plus4 = 32'h0; ex_csr_rdata = 32'h0;
  endtask

  initial begin
    vecs[0]  = mk(1, 1, 0, 5'd5,  2'b00, 3'b000, 32'h1234_5678, 0, 0, 0, 1, 32'h1234_5678);
    vecs[1]  = mk(1, 1, 0, 5'd1,  2'b01, 3'b000, 32'h0000_1003, 0, 0, 32'h80FF_7F01, 1, 32'hFFFF_FF80);
    vecs[2]  = mk(1, 1, 0, 5'd2,  2'b01, 3'b100, 32'h0000_1001, 0, 0, 32'h80FF_7F01, 1, 32'h0000_007F);
    vecs[3]  = mk(1, 1, 0, 5'd3,  2'b01, 3'b001, 32'h0000_1002, 0, 0, 32'h80FF_7F01, 1, 32'hFFFF_80FF);
    vecs[4]  = mk(1, 1, 0, 5'd4,  2'b01, 3'b101, 32'h0000_1000, 0, 0, 32'h80FF_7F01, 1, 32'h0000_7F01);
    vecs[5]  = mk(1, 1, 0, 5'd6,  2'b01, 3'b010, 32'h0000_1000, 0, 0, 32'h80FF_7F01, 1, 32'h80FF_7F01);
    vecs[6]  = mk(1, 1, 0, 5'd7,  2'b01, 3'b001, 32'h0000_1003, 0, 0, 32'h80FF_7F01, 1, 32'hFFFF_80FF);
    vecs[7]  = mk(1, 1, 0, 5'd8,  2'b01, 3'b011, 32'h0000_1002, 0, 0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
    vecs[8]  = mk(1, 1, 0, 5'd9,  2'b01, 3'b000, 32'h0000_1000, 0, 0, 32'h1234_5601, 1, 32'h0000_0001);
    vecs[9]  = mk(1, 1, 0, 5'd10, 2'b10, 3'b000, 32'h0,  32'h100, 0, 0, 1, 32'h0000_0100);
    vecs[10] = mk(1, 1, 0, 5'd11, 2'b11, 3'b000, 32'h0,  0, 32'hDEAD, 0, 1, 32'h0000_DEAD);
    vecs[11] = mk(1, 1, 0, 5'd0,  2'b00, 3'b000, 32'h77, 0, 0, 0, 0, 32'h0000_0077);
    vecs[12] = mk(1, 0, 0, 5'd12, 2'b00, 3'b000, 32'h88, 0, 0, 0, 0, 32'h0000_0088);
    vecs[13] = mk(1, 1, 1, 5'd13, 2'b00, 3'b000, 32'h99, 0, 0, 0, 0, 32'h0000_0099);
    vecs[14] = mk(0, 1, 0, 5'd14, 2'b00, 3'b000, 32'hAA, 0, 0, 0, 0, 32'h0000_00AA);

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; dmem_rdata = 32'h0;
    drive_ex(1'b0, 5'd0, 2'b00, 3'b000, 32'h0);
    #2;
    chk("reset rf_we", {31'b0, rf_we}, 32'h0);
    chk("reset rf_wa", {27'b0, rf_wa}, 32'h0);
    chk("reset rf_wd", rf_wd, 32'h0);
    chk("reset fwd_valid", {31'b0, fwd_valid}, 32'h0);
    chk("reset instret", instret, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      ex_valid = vecs[i].valid; ex_reg_we = vecs[i].reg_we; ex_rd = vecs[i].rd;
      ex_wb_sel = vecs[i].sel; ex_funct3 = vecs[i].f3; ex_alu_result = vecs[i].alu;
      ex_pc_plus4 = vecs[i].pc4; ex_csr_rdata = vecs[i].csr; flush = vecs[i].flush;
      sb.push_back('{vecs[i].exp_we, vecs[i].rd, vecs[i].exp_wd, exp_cnt});
      if (vecs[i].valid && !vecs[i].flush) exp_cnt++;
      @(posedge clk);
      #1 dmem_rdata = vecs[i].dmem;
      @(negedge clk);
      begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("vec%0d rf_we", i), {31'b0, rf_we}, {31'b0, e.we});
        chk($sformatf("vec%0d rf_wa", i), {27'b0, rf_wa}, {27'b0, e.wa});
        chk($sformatf("vec%0d rf_wd", i), rf_wd, e.wd);
        chk($sformatf("vec%0d fwd", i), {fwd_valid, fwd_rd, fwd_data[25:0]},
            {e.we, e.wa, e.wd[25:0]});
        chk($sformatf("vec%0d instret", i), instret, e.cnt);
      end
      ex_valid = 1'b0; flush = 1'b0;
    end

    // Stall hold: LW in WB, dmem changes under a 3-cycle stall, flush mid-stall ignored.
    @(negedge clk);
    drive_ex(1'b1, 5'd3, 2'b01, 3'b010, 32'h2000);
    @(posedge clk);
    #1 dmem_rdata = 32'hAAAA_AAAA;
    @(negedge clk);
    chk("stall pre wd", rf_wd, 32'hAAAA_AAAA);
    chk("stall pre instret", instret, exp_cnt);
    exp_cnt++;
    drive_ex(1'b1, 5'd6, 2'b00, 3'b000, 32'h6666);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      flush = (k == 1);
      @(posedge clk);
      #1 dmem_rdata = 32'h5555_5555;
      @(negedge clk);
      chk($sformatf("stall%0d wd", k), rf_wd, 32'hAAAA_AAAA);
      chk($sformatf("stall%0d we/wa", k), {26'b0, rf_we, rf_wa}, {26'b0, 1'b1, 5'd3});
      chk($sformatf("stall%0d instret", k), instret, exp_cnt - 1);
    end
    stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("release instret", instret, exp_cnt);
    chk("release wd", rf_wd, 32'h6666);
    chk("release wa", {27'b0, rf_wa}, 32'd6);
    exp_cnt++;
    ex_valid = 1'b0;

    // Async reset while stalled with a live write.
    @(negedge clk);
    drive_ex(1'b1, 5'd4, 2'b00, 3'b000, 32'h44);
    @(negedge clk);
    ex_valid = 1'b0; stall = 1'b1;
    @(posedge clk);
    #1;
    chk("midstall rf_we", {31'b0, rf_we}, 32'h1);
    chk("midstall hold", {31'b0, dut.hold}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async rf_we", {31'b0, rf_we}, 32'h0);
    chk("async fwd_valid", {31'b0, fwd_valid}, 32'h0);
    chk("async instret", instret, 32'h0);
    chk("async hold", {31'b0, dut.hold}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;
    exp_cnt = 0;

    // Wrap on the 4-bit counter instance after 16 retirements.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      drive_ex(1'b1, 5'd1, 2'b00, 3'b000, 32'(k));
    end
    @(negedge clk);
    ex_valid = 1'b0;
    chk("wrap pre small", {28'b0, w_instret}, 32'd15);
    @(posedge clk);
    @(negedge clk);
    chk("wrap small", {28'b0, w_instret}, 32'd0);
    chk("wrap big", instret, 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
